full_adder: RTL and testbench
=============================

# full_adder

Parameterizable ripple-carry full adder with a combinational result path and a registered, valid-qualified copy of the same result. With WIDTH=1 it is the classic one-bit full adder cell. Wider instances serve as the small-operand add stage in datapath blocks. Downstream logic reads either the combinational outputs or the one-cycle-registered outputs.

## Interface
- WIDTH, default 1: operand and sum width in bits; legal range 1–64.
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- in_valid  input  1  capture strobe for the registered outputs.
- sum  output  WIDTH  combinational sum bits of a+b+c_in.
- c_out  output  1  combinational carry out of the MSB.
- sum_q  output  WIDTH  registered sum.
- c_out_q  output  1  registered carry.
- out_valid  output  1  registered copy of in_valid.
- ovf_q  output  1  registered signed overflow; present only with FULL_ADDER_OVF_EN.

## Operation
- Combinational path: {c_out, sum} = a + b + c_in, computed as a WIDTH+1-bit unsigned result.
  - Bit i uses sum[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = c_in and c_out = c[WIDTH].
  - This path does not depend on clk or rst_n, so it is valid during reset.
- Registered path:
  - On a rising clk edge with in_valid=1, sum_q and c_out_q load sum and c_out.
  - With in_valid=0 they hold their previous values.
  - out_valid loads in_valid on every edge.
- Wrap-around: the sum is modulo 2^WIDTH and the carry is reported on c_out. Maximum case: all-ones + all-ones + 1 gives sum = all-ones, c_out = 1.
- X or Z on any input propagates to the combinational outputs. There is no masking.

## Timing
- Combinational outputs have zero-cycle latency and a purely ripple delay of O(WIDTH).
- Registered outputs have one-cycle latency. Inputs applied before edge N appear on sum_q, c_out_q and out_valid after edge N.
- Reset: when rst_n falls, sum_q=0, c_out_q=0, out_valid=0 and ovf_q=0 immediately, without waiting for clk.
  - Release is synchronous to the next clk edge.
  - Assertion mid-operation discards any pending capture.
- If in_valid=1 on the first edge after reset release, that capture takes effect normally.
- There is no backpressure. Every in_valid=1 edge overwrites the registers.

## Configuration
- FULL_ADDER_OVF_EN defined:
  - The ovf_q port exists.
  - On each capture edge it loads c[WIDTH-1] ^ c[WIDTH], the two's-complement overflow.
  - It holds when in_valid=0 and resets to 0.
- FULL_ADDER_OVF_EN undefined: the ovf_q port and its register are absent. All other behaviour is unchanged.

## Structure
- Shared package full_adder_pkg holds:
  - the WIDTH legality bounds MIN_WIDTH=1 and MAX_WIDTH=64;
  - a reset-value constant for the registered outputs (all zero).
- Sub-module full_adder_cell is the one-bit combinational cell (a, b, ci to s, co).
  - It is instantiated WIDTH times in a generate loop with the carry chained.
- The top level contains the carry chain, the output registers and an elaboration-time WIDTH range check.

## Test plan
- WIDTH=1, combinational truth table: all 8 input combinations of a, b, c_in, including these cases:
  - 1,1,1 gives sum=1, c_out=1.
  - 1,0,1 gives sum=0, c_out=1.
  - 0,0,0 gives sum=0, c_out=0.
- WIDTH=1, random stimulus: 10 random triples applied 10 time units apart → sum equals the XOR of the three inputs and c_out equals their majority on every sample.
- WIDTH=4 wrap: a=0xF, b=0x1, c_in=0 gives sum=0x0 and c_out=1. After one edge with in_valid=1: sum_q=0x0, c_out_q=1, out_valid=1.
- Hold: capture a=0x3, b=0x4, c_in=1 (sum_q=0x8), then change inputs with in_valid=0 for 3 cycles → sum_q stays 0x8 and out_valid=0.
- Reset mid-operation: drop rst_n between clock edges while sum_q=0x8 → sum_q, c_out_q and out_valid go to 0 immediately, and combinational sum still tracks the inputs.
- FULL_ADDER_OVF_EN, WIDTH=4: a=0x7, b=0x1, c_in=0 gives ovf_q=1 after capture. a=0xF, b=0x1 gives ovf_q=0 (c_out=1 but no signed overflow).

Source files
------------

// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants for the full_adder block:
//   MIN_WIDTH / MAX_WIDTH : legal range of the WIDTH parameter
//   RESET_BIT             : reset value of every bit of the registered outputs
// -----------------------------------------------------------------------------
package full_adder_pkg;

    localparam int   MIN_WIDTH = 1;
    localparam int   MAX_WIDTH = 64;
    localparam logic RESET_BIT = 1'b0;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// One-bit combinational full adder cell.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit      = a ^ b ^ ci
//   co   : carry out    = a&b | ci&(a^b)
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half;

    assign half = a ^ b;
    assign s    = half ^ ci;
    assign co   = (a & b) | (ci & half);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Parameterizable ripple-carry adder with a combinational result and a
// one-cycle registered, valid-qualified copy of the same result.
//
// Parameters:
//   WIDTH     : operand / sum width, 1..64
//
// Ports:
//   clk       : rising-edge clock for the registered outputs
//   rst_n     : asynchronous active-low reset (registered outputs only)
//   a, b      : unsigned operands
//   c_in      : carry into bit 0
//   in_valid  : capture strobe for sum_q / c_out_q (/ ovf_q)
//   sum       : combinational sum of a + b + c_in (mod 2^WIDTH)
//   c_out     : combinational carry out of the MSB
//   sum_q     : registered sum
//   c_out_q   : registered carry
//   out_valid : in_valid delayed by one clock
//   ovf_q     : registered two's-complement overflow (only when the macro
//               FULL_ADDER_OVF_EN is defined)
//
// Configuration macro: FULL_ADDER_OVF_EN adds the ovf_q port and register.
// -----------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_out_q,
    output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf_q
`endif
);

    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_width_check
        $error("full_adder: WIDTH=%0d outside legal range %0d..%0d",
               WIDTH, MIN_WIDTH, MAX_WIDTH);
    end

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign c_out = carry[WIDTH];

    // Stage boundary: combinational result -> registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= {WIDTH{RESET_BIT}};
            c_out_q   <= RESET_BIT;
            out_valid <= RESET_BIT;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                c_out_q <= c_out;
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= RESET_BIT;
        end else if (in_valid) begin
            ovf_q <= carry[WIDTH-1] ^ carry[WIDTH];
        end
    end
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic       clk;
    logic       rst_n;

    // WIDTH=1 instance
    logic       a1, b1, c1, v1;
    logic       s1, co1, sq1, coq1, ov1;
    // WIDTH=4 instance
    logic [3:0] a4, b4;
    logic       c4, v4;
    logic [3:0] s4, sq4;
    logic       co4, coq4, ov4;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf1, ovf4;
`endif

    int total = 0;
    int bad   = 0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .c_in      (c1),
        .in_valid  (v1),
        .sum       (s1),
        .c_out     (co1),
        .sum_q     (sq1),
        .c_out_q   (coq1),
        .out_valid (ov1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf_q     (ovf1)
`endif
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .c_in      (c4),
        .in_valid  (v4),
        .sum       (s4),
        .c_out     (co4),
        .sum_q     (sq4),
        .c_out_q   (coq4),
        .out_valid (ov4)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf_q     (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        a4 = 4'h5; b4 = 4'h6; c4 = 1'b0; v4 = 1'b1;
        tick();
        total++;
        if ({sq4, coq4, ov4} !== 5'b0) begin
            bad++;
            $display("FAIL reset_w4: got sum_q=%h c_out_q=%b out_valid=%b want 0 0 0", sq4, coq4, ov4);
        end
        total++;
        if ({sq1, coq1, ov1} !== 3'b0) begin
            bad++;
            $display("FAIL reset_w1: got sum_q=%b c_out_q=%b out_valid=%b want 0 0 0", sq1, coq1, ov1);
        end
        total++;
        if ({co4, s4} !== 5'h0B) begin
            bad++;
            $display("FAIL comb_in_reset: got c_out=%b sum=%h want 0 b", co4, s4);
        end
`ifdef FULL_ADDER_OVF_EN
        total++;
        if ({ovf1, ovf4} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ovf: got %b%b want 00", ovf1, ovf4);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        v1 = 1'b0;
        v4 = 1'b0;
        tick();
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] idx;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
            #1;
            total++;
            if ({co1, s1} !== {exp_c[i], exp_s[i]}) begin
                bad++;
                $display("FAIL truth_%0d%0d%0d: got c_out=%b sum=%b want %b %b",
                         idx[2], idx[1], idx[0], co1, s1, exp_c[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_random();
        logic es, ec;
        for (int i = 0; i < 10; i++) begin
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            #1;
            es = a1 ^ b1 ^ c1;
            ec = (a1 & b1) | (a1 & c1) | (b1 & c1);
            total++;
            if ({co1, s1} !== {ec, es}) begin
                bad++;
                $display("FAIL random_%0d: a=%b b=%b c=%b got c_out=%b sum=%b want %b %b",
                         i, a1, b1, c1, co1, s1, ec, es);
            end
            #9;
        end
    endtask

    task automatic test_reg_w1();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        total++;
        if ({sq1, coq1, ov1} !== 3'b111) begin
            bad++;
            $display("FAIL reg_w1: got sum_q=%b c_out_q=%b out_valid=%b want 1 1 1", sq1, coq1, ov1);
        end
    endtask

    task automatic test_wrap4();
        @(negedge clk);
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        #1;
        total++;
        if ({co4, s4} !== 5'h10) begin
            bad++;
            $display("FAIL wrap_comb: got c_out=%b sum=%h want 1 0", co4, s4);
        end
        tick();
        v4 = 1'b0;
        total++;
        if ({sq4, coq4, ov4} !== {4'h0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL wrap_reg: got sum_q=%h c_out_q=%b out_valid=%b want 0 1 1", sq4, coq4, ov4);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h4; c4 = 1'b1; v4 = 1'b1;
        tick();
        total++;
        if ({sq4, coq4, ov4} !== {4'h8, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hold_capture: got sum_q=%h c_out_q=%b out_valid=%b want 8 0 1", sq4, coq4, ov4);
        end
        v4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4 = 4'(4'hC + i); b4 = 4'h9; c4 = 1'b1;
            tick();
            total++;
            if ({sq4, coq4, ov4} !== {4'h8, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_%0d: got sum_q=%h c_out_q=%b out_valid=%b want 8 0 0", i, sq4, coq4, ov4);
            end
        end
    endtask

    task automatic test_reset_mid();
        // sum_q holds 0x8 here; a pending capture is set up then discarded.
        a4 = 4'h1; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sq4, coq4, ov4} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid: got sum_q=%h c_out_q=%b out_valid=%b want 0 0 0", sq4, coq4, ov4);
        end
        a4 = 4'h2; b4 = 4'h2;
        #1;
        total++;
        if ({co4, s4} !== 5'h04) begin
            bad++;
            $display("FAIL reset_mid_comb: got c_out=%b sum=%h want 0 4", co4, s4);
        end
        tick();
        total++;
        if ({sq4, coq4, ov4} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_held: got sum_q=%h c_out_q=%b out_valid=%b want 0 0 0", sq4, coq4, ov4);
        end
        // First edge after release captures normally: 9+9+1 = 0x13.
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'h9; b4 = 4'h9; c4 = 1'b1; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        total++;
        if ({sq4, coq4, ov4} !== {4'h3, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL release_capture: got sum_q=%h c_out_q=%b out_valid=%b want 3 1 1", sq4, coq4, ov4);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a4 = 4'h2; b4 = 4'h5; c4 = 1'b0; v4 = 1'b1;
        tick();
        total++;
        if ({sq4, coq4, ov4} !== {4'h7, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL b2b_0: got sum_q=%h c_out_q=%b out_valid=%b want 7 0 1", sq4, coq4, ov4);
        end
        a4 = 4'hA; b4 = 4'hB; c4 = 1'b1;
        tick();
        total++;
        if ({sq4, coq4, ov4} !== {4'h6, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL b2b_1: got sum_q=%h c_out_q=%b out_valid=%b want 6 1 1", sq4, coq4, ov4);
        end
        v4 = 1'b0;
    endtask

`ifdef FULL_ADDER_OVF_EN
    task automatic test_ovf();
        @(negedge clk);
        a4 = 4'h7; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        tick();
        total++;
        if ({ovf4, sq4} !== {1'b1, 4'h8}) begin
            bad++;
            $display("FAIL ovf_set: got ovf_q=%b sum_q=%h want 1 8", ovf4, sq4);
        end
        v4 = 1'b0;
        a4 = 4'hF;
        tick();
        total++;
        if (ovf4 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold: got ovf_q=%b want 1", ovf4);
        end
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        total++;
        if ({ovf4, coq4, sq4} !== {1'b0, 1'b1, 4'h0}) begin
            bad++;
            $display("FAIL ovf_clear: got ovf_q=%b c_out_q=%b sum_q=%h want 0 1 0", ovf4, coq4, sq4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_random();
        test_reg_w1();
        test_wrap4();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef FULL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_full_adder
